// File: rtl/axi_revision_pkg.sv
// axi_revision_pkg: shared register map, response codes, date layout and FSM state types for the revision reader and slave
package axi_revision_pkg;
    localparam int REG_MAJOR = 0;
    localparam int REG_MINOR = 1;
    localparam int REG_BUILD = 2;
    localparam int REG_DATE  = 3;
    localparam int NUM_REGS  = 4;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int DATE_MONTH_LSB = 24;
    localparam int DATE_DAY_LSB   = 16;
    localparam int DATE_YEAR_LSB  = 0;
    typedef enum logic [1:0] {IDLE, SEND_AR, WAIT_R, FINISH} seq_state_t;
    typedef enum logic [1:0] {ENG_IDLE, ENG_AR, ENG_R} eng_state_t;
    function automatic logic [3:0] reg_offset(input logic [1:0] idx);
        return {idx, 2'b00};
    endfunction
endpackage

// File: rtl/axi_lite_read_engine.sv
// axi_lite_read_engine: single AXI4-Lite read; req latches addr, ack pulses with data/resp on the R handshake
//   AXI_ACLK, AXI_RESET : clock, sync active-high reset
//   req, addr           : start one read at addr (only while idle or on the ack cycle)
//   ack, data, resp     : R handshake strobe with the returned word and RRESP
//   M_AXI_AR*, M_AXI_R* : AXI4-Lite read channels
module axi_lite_read_engine import axi_revision_pkg::*; #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  AXI_ACLK,
    input  logic                  AXI_RESET,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] data,
    output logic [1:0]            resp,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                  M_AXI_ARVALID,
    output logic [2:0]            M_AXI_ARPROT,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);
    eng_state_t state, state_next;
    logic [ADDR_WIDTH-1:0] araddr_q;

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            state    <= ENG_IDLE;
            araddr_q <= '0;
        end else begin
            state <= state_next;
            if (req) araddr_q <= addr;
        end
    end

    always_comb begin
        state_next = state;
        state_next = req ? ENG_AR
                   : (state == ENG_AR && M_AXI_ARREADY) ? ENG_R
                   : (state == ENG_R && M_AXI_RVALID) ? ENG_IDLE
                   : state;
    end

    assign M_AXI_ARVALID = state == ENG_AR;
    assign M_AXI_RREADY  = state == ENG_R;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign ack  = M_AXI_RVALID && M_AXI_RREADY;
    assign data = M_AXI_RDATA;
    assign resp = M_AXI_RRESP;
endmodule

// File: rtl/axi_revision_reader.sv
// axi_revision_reader: on START reads the four revision registers over AXI4-Lite and presents them as flat outputs
//   AXI_ACLK, AXI_RESET          : clock, sync active-high reset
//   START                        : one-cycle request, ignored unless idle
//   BUSY, DONE, VALID, ERROR     : sequence status; VALID sticky, ERROR = any non-OKAY response
//   MAJOR, MINOR, BUILD, DATE    : captured words (0 where the response was an error)
//   DATE_MONTH/DAY/YEAR          : fields of DATE
//   M_AXI_AR*, M_AXI_R*          : AXI4-Lite read master channels
module axi_revision_reader import axi_revision_pkg::*; #(
    parameter int                          M_AXI_ADDR_WIDTH = 4,
    parameter int                          M_AXI_DATA_WIDTH = 32,
    parameter logic [M_AXI_ADDR_WIDTH-1:0] BASE_ADDR        = '0
) (
    input  logic                        AXI_ACLK,
    input  logic                        AXI_RESET,
    input  logic                        START,
    output logic                        BUSY,
    output logic                        DONE,
    output logic                        VALID,
    output logic                        ERROR,
    output logic [M_AXI_DATA_WIDTH-1:0] MAJOR,
    output logic [M_AXI_DATA_WIDTH-1:0] MINOR,
    output logic [M_AXI_DATA_WIDTH-1:0] BUILD,
    output logic [M_AXI_DATA_WIDTH-1:0] DATE,
    output logic [7:0]                  DATE_MONTH,
    output logic [7:0]                  DATE_DAY,
    output logic [15:0]                 DATE_YEAR,
    output logic [M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                        M_AXI_ARVALID,
    output logic [2:0]                  M_AXI_ARPROT,
    input  logic                        M_AXI_ARREADY,
    input  logic [M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                  M_AXI_RRESP,
    input  logic                        M_AXI_RVALID,
    output logic                        M_AXI_RREADY
);
    seq_state_t state, state_next;
    logic [1:0] index, req_index;
    logic req, ack, error_q, valid_q;
    logic [1:0] rd_resp;
    logic [M_AXI_DATA_WIDTH-1:0] rd_data;
    logic [M_AXI_DATA_WIDTH-1:0] words [NUM_REGS];
    logic [M_AXI_ADDR_WIDTH-1:0] req_addr;

    // Wraps modulo 2^M_AXI_ADDR_WIDTH by truncation.
    assign req_addr = BASE_ADDR + M_AXI_ADDR_WIDTH'(reg_offset(req_index));

    axi_lite_read_engine #(
        .ADDR_WIDTH(M_AXI_ADDR_WIDTH),
        .DATA_WIDTH(M_AXI_DATA_WIDTH)
    ) u_engine (
        .AXI_ACLK     (AXI_ACLK),
        .AXI_RESET    (AXI_RESET),
        .req          (req),
        .addr         (req_addr),
        .ack          (ack),
        .data         (rd_data),
        .resp         (rd_resp),
        .M_AXI_ARADDR (M_AXI_ARADDR),
        .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARPROT (M_AXI_ARPROT),
        .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA  (M_AXI_RDATA),
        .M_AXI_RRESP  (M_AXI_RRESP),
        .M_AXI_RVALID (M_AXI_RVALID),
        .M_AXI_RREADY (M_AXI_RREADY)
    );

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            state   <= IDLE;
            index   <= '0;
            error_q <= 1'b0;
            valid_q <= 1'b0;
            words   <= '{default: '0};
        end else begin
            state <= state_next;
            if (state == IDLE && START) begin
                index   <= '0;
                error_q <= 1'b0;
                valid_q <= 1'b0;
                words   <= '{default: '0};
            end
            if (ack) begin
                words[index] <= rd_resp == RESP_OKAY ? rd_data : '0;
                error_q      <= error_q | (rd_resp != RESP_OKAY);
                valid_q      <= valid_q | (index == 2'd3);
                index        <= index + 2'd1;
            end
        end
    end

    // The next read is requested on the same cycle as the R handshake so AR follows one cycle later.
    always_comb begin
        state_next = state;
        req        = 1'b0;
        req_index  = '0;
        case (state)
            IDLE: begin
                req        = START;
                state_next = START ? SEND_AR : IDLE;
            end
            SEND_AR: state_next = (M_AXI_ARVALID && M_AXI_ARREADY) ? WAIT_R : SEND_AR;
            WAIT_R: begin
                req        = ack && index != 2'd3;
                req_index  = index + 2'd1;
                state_next = !ack ? WAIT_R : index == 2'd3 ? FINISH : SEND_AR;
            end
            default: state_next = IDLE;
        endcase
    end

    assign BUSY       = state == SEND_AR || state == WAIT_R;
    assign DONE       = state == FINISH;
    assign VALID      = valid_q;
    assign ERROR      = error_q;
    assign MAJOR      = words[REG_MAJOR];
    assign MINOR      = words[REG_MINOR];
    assign BUILD      = words[REG_BUILD];
    assign DATE       = words[REG_DATE];
    assign DATE_MONTH = DATE[DATE_MONTH_LSB +: 8];
    assign DATE_DAY   = DATE[DATE_DAY_LSB +: 8];
    assign DATE_YEAR  = DATE[DATE_YEAR_LSB +: 16];
endmodule

// File: tb/tb_axi_revision_reader.sv
// tb_axi_revision_reader: three reader instances (4-bit base 0, 8-bit base 0x40, 8-bit base 0xF8) against a behavioural slave and cycle model
module tb_axi_revision_reader;
    import axi_revision_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start;
    int stall, err_idx;
    logic [31:0] rom [4];
    int checks = 0, passes = 0;
    bit armed = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    for (genvar i = 0; i < 3; i++) begin : g
        localparam int AW = i == 0 ? 4 : 8;
        localparam logic [AW-1:0] BA = AW'(i == 0 ? 0 : i == 1 ? 'h40 : 'hF8);
        logic arvalid, arready, rvalid, rready, busy, done, valid, error;
        logic [2:0] arprot;
        logic [1:0] rresp;
        logic [31:0] rdata, major, minor, build, date;
        logic [7:0] dmon, dday;
        logic [15:0] dyear;
        logic [AW-1:0] aa;
        int wcnt;
        int ar_n, done_n;
        logic [7:0] ar_log [8];
        bit act = 1'b0;
        int n = 0, ms = 0, mer = -1;
        logic [31:0] mw [4] = '{default: 0};
        bit mv = 1'b0, me = 1'b0;

        axi_revision_reader #(
            .M_AXI_ADDR_WIDTH(AW),
            .M_AXI_DATA_WIDTH(32),
            .BASE_ADDR(BA)
        ) dut (
            .AXI_ACLK(clk), .AXI_RESET(rst), .START(start),
            .BUSY(busy), .DONE(done), .VALID(valid), .ERROR(error),
            .MAJOR(major), .MINOR(minor), .BUILD(build), .DATE(date),
            .DATE_MONTH(dmon), .DATE_DAY(dday), .DATE_YEAR(dyear),
            .M_AXI_ARADDR(aa), .M_AXI_ARVALID(arvalid), .M_AXI_ARPROT(arprot),
            .M_AXI_ARREADY(arready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
            .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
        );

        assign arready = arvalid && wcnt >= stall;

        always @(posedge clk) begin
            logic [AW-1:0] off;
            if (rst) begin
                wcnt   <= 0;
                rvalid <= 1'b0;
                rdata  <= '0;
                rresp  <= RESP_OKAY;
            end else begin
                if (arvalid && !arready) wcnt <= wcnt + 1;
                else if (arready) wcnt <= 0;
                if (arvalid && arready) begin
                    off = aa - BA;
                    rvalid <= 1'b1;
                    rdata  <= rom[off[3:2]];
                    rresp  <= int'(off[3:2]) == err_idx ? RESP_SLVERR : RESP_OKAY;
                end else if (rvalid && rready) rvalid <= 1'b0;
            end
        end

        // Cycle model: n counts cycles since the accepted START edge; each read takes ms+2 cycles.
        always @(posedge clk) begin
            int k;
            if (rst) armed = 1'b1;
            if (!rst && arvalid && arready) begin
                if (ar_n < 8) ar_log[ar_n] = 8'(aa);
                ar_n++;
            end
            if (!rst && done) done_n++;
            if (rst) begin
                act = 1'b0; n = 0; mv = 1'b0; me = 1'b0; mw = '{default: 0};
            end else if (act && n == 4 * (ms + 2) + 1) begin
                act = 1'b0;
            end else if (act) begin
                if ((n - 1) % (ms + 2) == ms + 1) begin
                    k = (n - 1) / (ms + 2);
                    mw[k] = k == mer ? 32'd0 : rom[k];
                    if (k == mer) me = 1'b1;
                    if (k == 3) mv = 1'b1;
                end
                n++;
            end else if (start) begin
                act = 1'b1; n = 1; mv = 1'b0; me = 1'b0; mw = '{default: 0};
                ms = stall; mer = err_idx; ar_n = 0; done_n = 0;
            end
        end

        always @(posedge clk) begin
            int k, p, d;
            logic e_arv, e_rr;
            #1;
            if (armed) begin
                d = 4 * (ms + 2) + 1;
                k = (n - 1) / (ms + 2);
                p = (n - 1) % (ms + 2);
                e_arv = act && n < d && p <= ms;
                e_rr  = act && n < d && p == ms + 1;
                chk($sformatf("g%0d arvalid n=%0d", i, n), 32'(arvalid), 32'(e_arv));
                chk($sformatf("g%0d rready n=%0d", i, n), 32'(rready), 32'(e_rr));
                chk($sformatf("g%0d busy n=%0d", i, n), 32'(busy), 32'(act && n < d));
                chk($sformatf("g%0d done n=%0d", i, n), 32'(done), 32'(act && n == d));
                chk($sformatf("g%0d valid", i), 32'(valid), 32'(mv));
                chk($sformatf("g%0d error", i), 32'(error), 32'(me));
                chk($sformatf("g%0d arprot", i), 32'(arprot), 32'd0);
                chk($sformatf("g%0d major", i), major, mw[0]);
                chk($sformatf("g%0d minor", i), minor, mw[1]);
                chk($sformatf("g%0d build", i), build, mw[2]);
                chk($sformatf("g%0d date", i), date, mw[3]);
                chk($sformatf("g%0d month", i), 32'(dmon), mw[3] >> 24);
                chk($sformatf("g%0d day", i), 32'(dday), (mw[3] >> 16) % 256);
                chk($sformatf("g%0d year", i), 32'(dyear), mw[3] % 65536);
                if (e_arv) chk($sformatf("g%0d araddr n=%0d", i, n), 32'(aa), 32'((int'(BA) + 4 * k) % (1 << AW)));
            end
        end
    end

    task automatic run(input int st, input int er, input int restart, output int dcyc);
        int cyc;
        stall = st;
        err_idx = er;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        while (g[0].done !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            start = cyc == restart;
        end
        start = 1'b0;
        dcyc = cyc;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d;
        rst = 1'b1;
        start = 1'b0;
        stall = 0;
        err_idx = -1;
        rom = '{32'd1, 32'd0, 32'd0, 32'h071B07E6};
        repeat (3) @(posedge clk);
        #1;
        chk("rst arvalid", 32'(g[0].arvalid), 0);
        chk("rst rready", 32'(g[0].rready), 0);
        chk("rst araddr", 32'(g[0].aa), 0);
        chk("rst busy", 32'(g[0].busy), 0);
        chk("rst done", 32'(g[0].done), 0);
        chk("rst valid", 32'(g[0].valid), 0);
        chk("rst major", g[0].major, 0);
        @(negedge clk);
        rst = 1'b0;

        run(0, -1, 0, d);
        chk("zw done_cycle", d, 9);
        chk("zw major", g[0].major, 1);
        chk("zw minor", g[0].minor, 0);
        chk("zw build", g[0].build, 0);
        chk("zw month", 32'(g[0].dmon), 7);
        chk("zw day", 32'(g[0].dday), 27);
        chk("zw year", 32'(g[0].dyear), 2022);
        chk("zw valid", 32'(g[0].valid), 1);
        chk("zw error", 32'(g[0].error), 0);
        chk("b40 ar0", 32'(g[1].ar_log[0]), 32'h40);
        chk("b40 ar1", 32'(g[1].ar_log[1]), 32'h44);
        chk("b40 ar2", 32'(g[1].ar_log[2]), 32'h48);
        chk("b40 ar3", 32'(g[1].ar_log[3]), 32'h4C);
        chk("bF8 ar0", 32'(g[2].ar_log[0]), 32'hF8);
        chk("bF8 ar1", 32'(g[2].ar_log[1]), 32'hFC);
        chk("bF8 ar2", 32'(g[2].ar_log[2]), 32'h00);
        chk("bF8 ar3", 32'(g[2].ar_log[3]), 32'h04);
        chk("bF8 month", 32'(g[2].dmon), 7);

        run(3, -1, 0, d);
        chk("stall done_cycle", d, 21);
        chk("stall ar0", 32'(g[0].ar_log[0]), 32'h0);
        chk("stall ar1", 32'(g[0].ar_log[1]), 32'h4);
        chk("stall ar2", 32'(g[0].ar_log[2]), 32'h8);
        chk("stall ar3", 32'(g[0].ar_log[3]), 32'hC);
        chk("stall ar_count", g[0].ar_n, 4);

        rom = '{32'd2, 32'd5, 32'd9, 32'h0C1F07E7};
        run(0, 1, 0, d);
        chk("slverr done_cycle", d, 9);
        chk("slverr major", g[0].major, 2);
        chk("slverr minor", g[0].minor, 0);
        chk("slverr build", g[0].build, 9);
        chk("slverr date", g[0].date, 32'h0C1F07E7);
        chk("slverr error", 32'(g[0].error), 1);
        chk("slverr valid", 32'(g[0].valid), 1);
        chk("slverr done_count", g[0].done_n, 1);

        run(0, -1, 3, d);
        chk("restart done_cycle", d, 9);
        chk("restart ar_count", g[0].ar_n, 4);
        chk("restart done_count", g[0].done_n, 1);
        chk("restart busy", 32'(g[0].busy), 0);
        chk("restart error cleared", 32'(g[0].error), 0);

        stall = 0;
        err_idx = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("mid wait_r rready", 32'(g[0].rready), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid arvalid", 32'(g[0].arvalid), 0);
        chk("mid rready", 32'(g[0].rready), 0);
        chk("mid busy", 32'(g[0].busy), 0);
        chk("mid valid", 32'(g[0].valid), 0);
        chk("mid araddr", 32'(g[0].aa), 0);
        chk("mid major", g[0].major, 0);
        run(0, -1, 0, d);
        chk("post done_cycle", d, 9);
        chk("post major", g[0].major, 2);
        chk("post minor", g[0].minor, 5);
        chk("post valid", 32'(g[0].valid), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/axi_revision_reader.md
# axi_revision_reader

AXI4-Lite read-only master that sits directly upstream of the revision slave (four read-only registers: major, minor, build, packed date). On a START pulse it reads all four registers in order, latches them, and presents them as flat outputs with the date unpacked into month/day/year. Firmware-free consumers (status LEDs, boot banner logic, debug UART) use it to get the build version without a CPU.

## Interface
- M_AXI_ADDR_WIDTH, 4: read address width.
- M_AXI_DATA_WIDTH, 32: read data width; must be 32.
- BASE_ADDR, 0: byte address of the slave's register 0x00.
- AXI_ACLK  in  1  sole clock.
- AXI_RESET  in  1  reset; synchronous, active-high.
- START  in  1  single-cycle request to read all four registers.
- BUSY  out  1  high from the cycle after an accepted START until DONE.
- DONE  out  1  one-cycle pulse when the fourth read completes.
- VALID  out  1  sticky; outputs hold a completed read set.
- ERROR  out  1  set if any RRESP in the last sequence was non-OKAY.
- MAJOR, MINOR, BUILD, DATE  out  32 each  captured register words.
- DATE_MONTH  out  8  DATE[31:24].
- DATE_DAY  out  8  DATE[23:16].
- DATE_YEAR  out  16  DATE[15:0].
- M_AXI_ARADDR  out  M_AXI_ADDR_WIDTH; M_AXI_ARVALID out 1; M_AXI_ARPROT out 3 (constant 0); M_AXI_ARREADY in 1.
- M_AXI_RDATA  in  32; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1.
- No write channels.

## Operation
- States: IDLE, SEND_AR, WAIT_R, FINISH.
- IDLE: START=1 -> index=0, ERROR cleared, VALID cleared, captured words cleared. Next state is SEND_AR.
- SEND_AR: ARVALID=1, ARADDR=BASE_ADDR+4*index. Both are held stable until the AR handshake (ARVALID&ARREADY). After the handshake, next state is WAIT_R.
- WAIT_R: RREADY=1. On the R handshake:
  - RRESP==OKAY -> store RDATA into word[index].
  - Otherwise -> store 0 and set ERROR.
  - index<3 -> index+1 and go to SEND_AR. index==3 -> FINISH.
- FINISH: DONE=1 and VALID=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^M_AXI_ADDR_WIDTH; wrap is silent.
- START while not in IDLE is ignored and is not queued.
- RVALID arriving outside WAIT_R is not accepted, because RREADY=0.
- ERROR does not abort the sequence; all four reads are always issued.
- DATE_* are combinational slices of the DATE register.

## Timing
- Reset values: ARVALID=0, RREADY=0, ARADDR=0, BUSY=0, DONE=0, VALID=0, ERROR=0, all data outputs 0. State=IDLE.
- START sampled at edge t -> ARVALID=1 and BUSY=1 from cycle t+1.
- AR handshake at cycle c -> ARVALID=0 and RREADY=1 from c+1.
- R handshake at cycle c -> next ARVALID from c+1, or DONE at c+1 after the fourth read.
- Zero-wait slave (ARREADY=1; RVALID the cycle after the AR handshake): DONE at t+9.
- BUSY falls in the same cycle DONE rises.
- Master never asserts ARVALID and RREADY in the same cycle; at most one read is outstanding.
- Reset mid-sequence: all outputs return to reset values on the next edge. The system resets master and slave together, so an in-flight response does not survive.

## Structure
- Shared package axi_revision_pkg:
  - Register word indices REG_MAJOR=0, REG_MINOR=1, REG_BUILD=2, REG_DATE=3.
  - RRESP codes OKAY=0, SLVERR=2.
  - Date field bit positions.
- The revision slave imports the same package.
- One natural sub-module: axi_lite_read_engine. It performs a single-address read handshake (req/addr in; ack/data/resp out). The top level sequences the four indices through it.

## Test plan
- Zero-wait slave returning 1, 0, 0, 0x071B07E6; START at t -> MAJOR=1, MINOR=0, BUILD=0, DATE_MONTH=7, DATE_DAY=27, DATE_YEAR=2022, DONE at t+9, VALID=1, ERROR=0.
- ARREADY held low 3 cycles on each read -> ARVALID and ARADDR stay stable while stalled; ARADDR sequence is 0x0, 0x4, 0x8, 0xC; DONE at t+21.
- RRESP=SLVERR on the MINOR read -> MINOR=0, ERROR=1, other three words captured, DONE still pulses once.
- START pulsed again at t+3 during BUSY -> exactly 4 AR handshakes, a single DONE, and no second sequence.
- AXI_RESET asserted during WAIT_R of read 2 -> next cycle ARVALID=0, RREADY=0, BUSY=0, VALID=0, all words 0. A new START then completes normally.
- M_AXI_ADDR_WIDTH=8, BASE_ADDR=0x40 -> ARADDR 0x40, 0x44, 0x48, 0x4C. BASE_ADDR=0xF8 -> 0xF8, 0xFC, 0x00, 0x04, showing the silent wrap.
